// File: rtl/usr_pkg.sv
// Shared types and constants for the usr serial-shift transmitter.
package usr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/usr_bit_counter.sv
// Modulo-DW bit counter; terminal flags the last bit of a word.
module usr_bit_counter #(
    parameter int DW = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enb_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic terminal_o
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign terminal_o = (cnt_q == CW'(DW - 1));

    // Wrap explicitly at DW-1 so non-power-of-two widths stay modulo-DW.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && enb_i) begin
            cnt_d = terminal_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/usr_piso_tx.sv
// Parallel-in/serial-out transmitter feeding a usr in serial-shift mode.
// state | meaning
// IDLE  | waiting for a word, o_ready high
// SHIFT | one data bit per enabled cycle, o_frame high
// DONE  | one-state pulse after last bit, can accept next word
module usr_piso_tx
    import usr_pkg::*;
#(
    parameter int   DW       = 8,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enb,
    input  logic          i_valid,
    input  logic [DW-1:0] i_parallel,
    input  logic          i_dir,
    output logic          o_ready,
    output logic          o_serial,
    output logic          o_frame,
    output logic          o_busy,
    output logic          o_done
);

    tx_state_t     state_q, state_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic          dir_q, dir_d;
    logic          accept;
    logic          cnt_clear, cnt_inc, cnt_terminal;

    usr_bit_counter #(.DW(DW)) u_bit_counter (
        .clk_i      (clock),
        .rst_i      (reset),
        .enb_i      (enb),
        .clear_i    (cnt_clear),
        .inc_i      (cnt_inc),
        .terminal_o (cnt_terminal)
    );

    assign o_ready  = (state_q != SHIFT);
    assign o_frame  = (state_q == SHIFT);
    assign o_busy   = (state_q == SHIFT);
    assign o_done   = (state_q == DONE);
    assign o_serial = (state_q == SHIFT) ? ((dir_q == DIR_MSB_FIRST) ? shreg_q[DW-1] : shreg_q[0])
                                         : IDLE_LVL;
    assign accept   = enb && i_valid && o_ready;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        dir_d     = dir_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    shreg_d   = i_parallel;
                    dir_d     = i_dir;
                    cnt_clear = 1'b1;
                    state_d   = SHIFT;
                end else if (enb) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (enb) begin
                    cnt_inc = 1'b1;
                    shreg_d = (dir_q == DIR_MSB_FIRST) ? {shreg_q[DW-2:0], 1'b0}
                                                       : {1'b0, shreg_q[DW-1:1]};
                    if (cnt_terminal) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            dir_q   <= DIR_LSB_FIRST;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dir_q   <= dir_d;
        end
    end

endmodule
